// File: rtl/lpc_ctrl_pkg.sv
// Shared definitions for the Q-channel low-power controller: the state
// encoding that also appears on state_o, and the channel-count limit.
package lpc_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam int MAX_CH  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_REQ     = 2'd1,
        ST_STOPPED = 2'd2,
        ST_EXIT    = 2'd3
    } state_t;

endpackage

// File: rtl/lpc_sync2.sv
// Two-flop synchronizer of parameterised width. The reset value is a
// parameter so each bus can come out of reset at its idle level.
module lpc_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lpc_q_controller.sv
// Q-channel power controller. It counts idle cycles and then lowers QREQn
// on the participating channels. Once every one of them has accepted, it
// gates the shared clock enable. A wakeup reverses the handshake.
// Optional build macro: LPC_CTRL_WAKE_SYNC_EN adds two-flop synchronizers
// on qactive_i, qacceptn_i and wake_i. Each of these inputs then takes
// two cycles longer to reach the outputs.
//
// state   | meaning
// RUN     | clock running, counting consecutive idle cycles
// REQ     | QREQn low on masked channels, waiting for all accepts
// STOPPED | all masked channels accepted, clock gated
// EXIT    | QREQn released, waiting for all masked accepts to rise
module lpc_q_controller
    import lpc_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_CH-1:0]  ch_en_i,
    input  logic               wake_i,
    input  logic [NUM_CH-1:0]  qactive_i,
    input  logic [NUM_CH-1:0]  qacceptn_i,
    output logic [NUM_CH-1:0]  qreqn_o,
    output logic               clk_en_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int               CNT_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

    logic [NUM_CH-1:0] qactive;
    logic [NUM_CH-1:0] qacceptn;
    logic              wake;

`ifdef LPC_CTRL_WAKE_SYNC_EN
    lpc_sync2 #(.WIDTH(NUM_CH), .RST_VAL({NUM_CH{1'b0}})) u_sync_qactive (
        .clk(clk), .reset_n(reset_n), .d(qactive_i), .q(qactive)
    );
    lpc_sync2 #(.WIDTH(NUM_CH), .RST_VAL({NUM_CH{1'b1}})) u_sync_qacceptn (
        .clk(clk), .reset_n(reset_n), .d(qacceptn_i), .q(qacceptn)
    );
    lpc_sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_wake (
        .clk(clk), .reset_n(reset_n), .d(wake_i), .q(wake)
    );
`else
    assign qactive  = qactive_i;
    assign qacceptn = qacceptn_i;
    assign wake     = wake_i;
`endif

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] mask_nx;
    logic [NUM_CH-1:0] qreqn_nx;
    logic              clk_en_nx;

    logic active;
    logic wakeup;
    logic all_accepted;
    logic all_released;

    // In RUN the live enables decide participation. After RUN the mask
    // latched at request entry decides it.
    assign active       = |(qactive & ((state == ST_RUN) ? ch_en_i : mask));
    assign wakeup       = active | wake;
    assign all_accepted = ((qacceptn & mask) == '0);
    assign all_released = ((qacceptn & mask) == mask);

    // State, idle counter, mask and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            cnt      <= '0;
            mask     <= '0;
            qreqn_o  <= '1;
            clk_en_o <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            mask     <= mask_nx;
            qreqn_o  <= qreqn_nx;
            clk_en_o <= clk_en_nx;
        end
    end

    // Next-state decision. REQ has no deny path. A wakeup seen there only
    // steers the exit once all accepts are in.
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:     if (cnt == IDLE_MAX && ch_en_i != '0) state_nx = ST_REQ;
            ST_REQ:     if (all_accepted) state_nx = wakeup ? ST_EXIT : ST_STOPPED;
            ST_STOPPED: if (wakeup) state_nx = ST_EXIT;
            ST_EXIT:    if (all_released) state_nx = ST_RUN;
            default:    state_nx = ST_RUN;
        endcase
    end

    // Next values for the counter, the mask and the outputs. The outputs
    // are derived from the next state so they change on the same edge as
    // the state does.
    always_comb begin
        mask_nx   = mask;
        cnt_nx    = '0;
        qreqn_nx  = '1;
        clk_en_nx = 1'b1;
        if (state == ST_RUN && state_nx == ST_REQ) begin
            mask_nx = ch_en_i;
        end
        if (state == ST_RUN && state_nx == ST_RUN && !wakeup) begin
            cnt_nx = (cnt == IDLE_MAX) ? cnt : cnt + CNT_W'(1);
        end
        if (state_nx == ST_REQ || state_nx == ST_STOPPED) begin
            qreqn_nx = ~mask_nx;
        end
        if (state_nx == ST_STOPPED) begin
            clk_en_nx = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_lpc_q_controller.sv
// Bench for lpc_q_controller in its default build. Directed scenarios come
// first, then randomized traffic against a cycle reference model.
module tb_lpc_q_controller;
    import lpc_ctrl_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int IDLE_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] ch_en;
    logic       wake;
    logic [3:0] qactive;
    logic [3:0] qacceptn;
    logic [3:0] qreqn;
    logic       clk_en;
    logic [1:0] state;

    always #5 clk = ~clk;

    lpc_q_controller #(.NUM_CH(NUM_CH), .IDLE_CYCLES(IDLE_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .ch_en_i(ch_en), .wake_i(wake),
        .qactive_i(qactive), .qacceptn_i(qacceptn),
        .qreqn_o(qreqn), .clk_en_o(clk_en), .state_o(state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model. The phase number is the externally visible state
    // code. The idle time is kept as a plain integer.
    int         m_phase;
    int         m_idle;
    logic [3:0] m_mask;

    task automatic model_reset();
        m_phase = 0;
        m_idle  = 0;
        m_mask  = 4'h0;
    endtask

    task automatic model_step();
        logic [3:0] part;
        bit         busy;
        part = (m_phase == 0) ? ch_en : m_mask;
        busy = (|(qactive & part)) || wake;
        case (m_phase)
            0: begin
                if (m_idle == IDLE_CYCLES && ch_en != 4'h0) begin
                    m_phase = 1;
                    m_mask  = ch_en;
                    m_idle  = 0;
                end else if (busy) begin
                    m_idle = 0;
                end else if (m_idle < IDLE_CYCLES) begin
                    m_idle = m_idle + 1;
                end
            end
            1: if ((qacceptn & m_mask) == 4'h0) m_phase = busy ? 3 : 2;
            2: if (busy) m_phase = 3;
            default: if ((qacceptn & m_mask) == m_mask) begin
                m_phase = 0;
                m_idle  = 0;
            end
        endcase
    endtask

    task automatic compare_model();
        logic [3:0] exp_qreqn;
        exp_qreqn = (m_phase == 1 || m_phase == 2) ? ~m_mask : 4'hF;
        chk("model_qreqn", 32'(qreqn), 32'(exp_qreqn));
        chk("model_clk_en", 32'(clk_en), 32'(m_phase != 2));
        chk("model_state", 32'(state), 32'(m_phase));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (qreqn == 4'hF && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, output int n);
        n = 0;
        while (state != s && n < 60) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        reset_n  = 1'b0;
        ch_en    = 4'hF;
        wake     = 1'b0;
        qactive  = 4'h0;
        qacceptn = 4'hF;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_qreqn", 32'(qreqn), 32'h0F);
        chk("rst_clk_en", 32'(clk_en), 32'h1);
        chk("rst_state", 32'(state), 32'h0);
        reset_n = 1'b1;

        // Idle entry: the request appears 17 edges after the counter starts.
        wait_req(n);
        chk("idle_entry_latency", 32'(n), 32'd17);
        chk("idle_entry_qreqn", 32'(qreqn), 32'h0);
        repeat (3) tick();
        qacceptn = 4'h0;
        tick();
        chk("stop_clk_en", 32'(clk_en), 32'h0);
        chk("stop_state", 32'(state), 32'h2);

        // Wake from stop.
        wake = 1'b1;
        tick();
        wake = 1'b0;
        chk("wake_qreqn", 32'(qreqn), 32'h0F);
        chk("wake_clk_en", 32'(clk_en), 32'h1);
        repeat (2) tick();
        chk("exit_hold_state", 32'(state), 32'h3);
        qacceptn = 4'hF;
        tick();
        chk("exit_to_run", 32'(state), 32'h0);

        // Idle counter clear by a pulse at count 10.
        repeat (10) tick();
        qactive[2] = 1'b1;
        tick();
        qactive[2] = 1'b0;
        wait_req(n);
        chk("idle_clear_latency", 32'(n), 32'd17);
        qacceptn = 4'h0;
        tick();
        wake = 1'b1;
        tick();
        wake = 1'b0;
        qacceptn = 4'hF;
        tick();

        // Masked channels 1 and 3 do not participate.
        ch_en = 4'b0101;
        wait_req(n);
        chk("mask_qreqn", 32'(qreqn), 32'hA);
        qacceptn = 4'b1010;
        tick();
        chk("mask_stopped", 32'(state), 32'h2);
        qactive[1] = 1'b1;
        repeat (3) tick();
        chk("mask_no_wake", 32'(state), 32'h2);
        qactive[1] = 1'b0;
        wake = 1'b1;
        tick();
        wake = 1'b0;
        qacceptn = 4'hF;
        tick();
        chk("mask_back_run", 32'(state), 32'h0);

        // Wake during request: clk_en must never drop.
        ch_en = 4'hF;
        wait_req(n);
        qactive[0] = 1'b1;
        repeat (3) tick();
        chk("req_hold_qreqn", 32'(qreqn), 32'h0);
        chk("req_hold_state", 32'(state), 32'h1);
        qacceptn = 4'h0;
        tick();
        chk("req_to_exit_state", 32'(state), 32'h3);
        chk("req_to_exit_clk_en", 32'(clk_en), 32'h1);
        qactive[0] = 1'b0;
        qacceptn = 4'hF;
        tick();

        // Asynchronous reset while stopped.
        wait_req(n);
        qacceptn = 4'h0;
        tick();
        chk("pre_reset_state", 32'(state), 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_qreqn", 32'(qreqn), 32'h0F);
        chk("async_rst_clk_en", 32'(clk_en), 32'h1);
        chk("async_rst_state", 32'(state), 32'h0);
        qacceptn = 4'hF;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic. Devices follow QREQn after a random delay.
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                qactive[i] = ($urandom_range(39) == 0);
                if (qacceptn[i] != qreqn[i] && $urandom_range(2) == 0)
                    qacceptn[i] = qreqn[i];
            end
            wake = ($urandom_range(59) == 0);
            if ($urandom_range(49) == 0) ch_en = 4'($urandom_range(15));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
